// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/LSU request logic, the arbiter and the
// single-ported unified memory. The arbiter connects through the slave
// modport; the core/memory side connects through the master modport.
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  // Load/store (data) port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  // Completion status shared by both requesters
  logic        err;
  // Memory side
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;
  // Status
  logic        arb_busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  m_ack, m_rdata,
    output if_done, if_rdata,
    output d_done, d_rdata,
    output err,
    output m_req, m_we, m_addr, m_wdata, m_be,
    output arb_busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output m_ack, m_rdata,
    input  if_done, if_rdata,
    input  d_done, d_rdata,
    input  err,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    input  arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the
// load/store port. One transaction outstanding at a time; data has fixed
// priority unless fetch has waited MAX_WAIT cycles. A missing memory ack
// turns into an error completion after TIMEOUT cycles in ACCESS.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_DATA, OWN_FETCH} owner_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  owner_t      owner;
  logic [7:0]  if_wait;
  logic [9:0]  tmo;
  logic        err_q;
  logic        grant_fetch, grant_data;
  logic        ack_hit, tmo_hit;
  logic        m_we_q;
  logic [31:0] m_addr_q, m_wdata_q;
  logic [3:0]  m_be_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  // Aging counter increment that sticks at the 8-bit ceiling.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Data handed back to the owner: stores and timed-out accesses return zero.
  function automatic logic [31:0] resp_data(input logic        timed_out,
                                            input logic        was_store,
                                            input logic [31:0] rd);
    return (timed_out || was_store) ? 32'd0 : rd;
  endfunction

  // Next-state logic, grant decision and completion detection.
  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    ack_hit     = 1'b0;
    tmo_hit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_req && (!bus.d_req || (if_wait >= MAX_WAIT_C))) begin
          grant_fetch = 1'b1;
        end else if (bus.d_req) begin
          grant_data = 1'b1;
        end
        if (grant_fetch || grant_data) state_nxt = ACCESS;
      end
      ACCESS: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        ack_hit = bus.m_ack;
        tmo_hit = !bus.m_ack && (tmo == TMO_LAST);
        if (ack_hit || tmo_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Owner, fetch aging counter, access timer and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= OWN_DATA;
      if_wait <= '0;
      tmo     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant_fetch)     owner <= OWN_FETCH;
      else if (grant_data) owner <= OWN_DATA;

      if (!bus.if_req || grant_fetch) if_wait <= '0;
      else                            if_wait <= sat_inc8(if_wait);

      if (state == ACCESS) tmo <= tmo + 10'd1;
      else                 tmo <= '0;

      if (ack_hit)      err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  // Memory command captured at grant and held stable through ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else if (grant_fetch) begin
      m_we_q    <= 1'b0;
      m_addr_q  <= bus.if_addr;
      m_wdata_q <= '0;
      m_be_q    <= 4'hF;
    end else if (grant_data) begin
      m_we_q    <= bus.d_we;
      m_addr_q  <= bus.d_addr;
      m_wdata_q <= bus.d_wdata;
      m_be_q    <= bus.d_we ? bus.d_be : 4'hF;
    end
  end

  // Per-requester read data, updated only when that requester's access ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (ack_hit || tmo_hit) begin
      if (owner == OWN_FETCH) if_rdata_q <= resp_data(tmo_hit, m_we_q, bus.m_rdata);
      else                    d_rdata_q  <= resp_data(tmo_hit, m_we_q, bus.m_rdata);
    end
  end

  assign bus.m_req    = (state == ACCESS);
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_be     = m_be_q;
  assign bus.if_done  = (state == RESP) && (owner == OWN_FETCH);
  assign bus.d_done   = (state == RESP) && (owner == OWN_DATA);
  assign bus.err      = (state == RESP) && err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.arb_busy = (state != IDLE);

endmodule
